// File: rtl/regfile_pkg.sv
// Shared constants for the windowed register file: window geometry and
// the bit positions of the {N,Z,V,C} condition-code flags.
package regfile_pkg;

    localparam int NWINDOWS_DEFAULT = 4;

    // Condition-code bit positions inside the 4-bit flags/icc vectors.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // r0-r7 are shared globals; each window contributes 16 fresh words
    // (its locals and outs; its ins are the next window's outs).
    localparam int GLOBALS  = 8;
    localparam int WIN_SIZE = 16;

endpackage

// File: rtl/window_index_map.sv
// Maps an architectural register number plus the current window pointer
// to a physical index into the flat register array.
module window_index_map
    import regfile_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEFAULT
) (
    input  logic [4:0]                    r,
    input  logic [$clog2(NWINDOWS)-1:0]   cwp,
    output logic [$clog2(NWINDOWS)+4:0]   phys
);

    localparam int CWPW = $clog2(NWINDOWS);
    // Offset within the circular windowed region; its width is exactly
    // log2(16*NWINDOWS), so the natural wrap of the adder is the modulo.
    localparam int OW   = CWPW + 4;
    localparam int PW   = CWPW + 5;

    logic [OW-1:0] offset;

    // Globals pass straight through; windowed registers rotate with cwp.
    // NOTE: every output of a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        phys   = PW'(r);
        offset = OW'(cwp) * OW'(WIN_SIZE) + OW'(r - 5'd8);
        if (r >= 5'(GLOBALS)) begin
            phys = PW'(GLOBALS) + PW'(offset);
        end
    end

endmodule

// File: rtl/windowed_regfile.sv
// SPARC-style windowed integer register file with an ICC register, feeding
// the ALU operands and taking the ALU result and flags back.
module windowed_regfile
    import regfile_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEFAULT,
    parameter int WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    ra_a,
    input  logic [4:0]                    ra_b,
    output logic [WIDTH-1:0]              rd_a,
    output logic [WIDTH-1:0]              rd_b,
    input  logic                          we,
    input  logic [4:0]                    wa,
    input  logic [WIDTH-1:0]              wd,
    input  logic                          save,
    input  logic                          restore,
    output logic [$clog2(NWINDOWS)-1:0]   cwp,
    output logic                          win_overflow,
    output logic                          win_underflow,
    input  logic                          icc_we,
    input  logic [3:0]                    flags_in,
    output logic [3:0]                    icc,
    output logic                          cin_out
);

    localparam int CWPW  = $clog2(NWINDOWS);
    localparam int PW    = CWPW + 5;
    localparam int NPHYS = GLOBALS + WIN_SIZE * NWINDOWS;

    logic [WIDTH-1:0] mem [NPHYS];
    logic [PW-1:0]    phys_a;
    logic [PW-1:0]    phys_b;
    logic [PW-1:0]    phys_w;
    logic [CWPW-1:0]  depth;

    // The write port uses the current (pre-update) cwp, so a write issued
    // together with save/restore lands in the window being left.
    window_index_map #(.NWINDOWS(NWINDOWS)) u_map_a (.r(ra_a), .cwp(cwp), .phys(phys_a));
    window_index_map #(.NWINDOWS(NWINDOWS)) u_map_b (.r(ra_b), .cwp(cwp), .phys(phys_b));
    window_index_map #(.NWINDOWS(NWINDOWS)) u_map_w (.r(wa),   .cwp(cwp), .phys(phys_w));

    // Register array: cleared on reset, written unless the target is r0.
    // NOTE: every word must read zero after reset, so the array is built from
    // resettable flops rather than an inferred RAM (which has no reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPHYS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            mem[phys_w] <= wd;
        end
    end

    // Combinational read ports with r0 forced to zero and write bypass.
    always_comb begin
        rd_a = mem[phys_a];
        if (ra_a == 5'd0) begin
            rd_a = '0;
        end else if (we && wa == ra_a) begin
            rd_a = wd;
        end
        rd_b = mem[phys_b];
        if (ra_b == 5'd0) begin
            rd_b = '0;
        end else if (we && wa == ra_b) begin
            rd_b = wd;
        end
    end

    // Window rotation with depth tracking; refused requests pulse a flag.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cwp           <= '0;
            depth         <= '0;
            win_overflow  <= 1'b0;
            win_underflow <= 1'b0;
        end else begin
            win_overflow  <= 1'b0;
            win_underflow <= 1'b0;
            if (save && !restore) begin
                if (depth == CWPW'(NWINDOWS - 1)) begin
                    win_overflow <= 1'b1;
                end else begin
                    cwp   <= cwp - CWPW'(1);
                    depth <= depth + CWPW'(1);
                end
            end else if (restore && !save) begin
                if (depth == '0) begin
                    win_underflow <= 1'b1;
                end else begin
                    cwp   <= cwp + CWPW'(1);
                    depth <= depth - CWPW'(1);
                end
            end
        end
    end

    // Condition-code register: loads ALU flags on icc_we, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            icc <= '0;
        end else if (icc_we) begin
            icc <= flags_in;
        end
    end

    assign cin_out = icc[FLAG_C];

endmodule

// File: tb/tb_windowed_regfile.sv
// Self-checking bench for windowed_regfile (NWINDOWS=4, WIDTH=32): reset
// sweep, then a table of per-cycle vectors with a scoreboard for the
// registered outputs.
module tb_windowed_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra_a, ra_b, wa;
    logic [31:0] rd_a, rd_b, wd;
    logic        we, save, restore, icc_we;
    logic [1:0]  cwp;
    logic        win_overflow, win_underflow;
    logic [3:0]  flags_in, icc;
    logic        cin_out;

    int checks = 0;
    int errors = 0;

    windowed_regfile #(.NWINDOWS(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b),
        .we(we), .wa(wa), .wd(wd),
        .save(save), .restore(restore), .cwp(cwp),
        .win_overflow(win_overflow), .win_underflow(win_underflow),
        .icc_we(icc_we), .flags_in(flags_in), .icc(icc), .cin_out(cin_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra_a;
        logic [4:0]  ra_b;
        logic        sv;
        logic        rs;
        logic        icc_we;
        logic [3:0]  flags;
        logic [31:0] e_a;      // rd_a during the cycle
        logic [31:0] e_b;      // rd_b during the cycle
        logic [1:0]  e_cwp;    // after the edge
        logic [3:0]  e_icc;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] cwp;
        logic [3:0] icc;
        logic       ovf;
        logic       unf;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] qa, input logic [4:0] qb, input logic s, input logic re,
                       input logic iw, input logic [3:0] f, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [1:0] ec, input logic [3:0] ei, input logic eo, input logic eu);
        vec_t v;
        v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ra_a = qa; v.ra_b = qb;
        v.sv = s; v.rs = re; v.icc_we = iw; v.flags = f;
        v.e_a = ea; v.e_b = eb; v.e_cwp = ec; v.e_icc = ei; v.e_ovf = eo; v.e_unf = eu;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra_a = '0; ra_b = '0;
        save = 1'b0; restore = 1'b0; icc_we = 1'b0; flags_in = '0;
    endtask

    initial begin
        post_t p;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state: registered outputs and every architectural register.
        #1;
        check("reset cwp", 32'(cwp), 32'd0);
        check("reset icc", 32'(icc), 32'd0);
        check("reset cin", 32'(cin_out), 32'd0);
        check("reset ovf", 32'(win_overflow), 32'd0);
        check("reset unf", 32'(win_underflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra_a = 5'(i);
            ra_b = 5'(31 - i);
            #1;
            check($sformatf("reset r%0d", i), rd_a, 32'd0);
            check($sformatf("reset r%0d b", 31 - i), rd_b, 32'd0);
        end

        //   rst we wa     wd            ra ra sv rs iw flags  e_a           e_b           cwp icc  ov un
        row(0, 1, 5'd5,  32'h0000_0001, 5,  0, 0, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        0, 4'h0, 0, 0);
        row(0, 1, 5'd8,  32'hBFFF_FFFF, 8,  5, 0, 0, 0, 4'h0, 32'hBFFF_FFFF, 32'h0000_0001, 0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         8,  5, 0, 0, 0, 4'h0, 32'hBFFF_FFFF, 32'h0000_0001, 0, 4'h0, 0, 0);
        row(0, 1, 5'd0,  32'hFFFF_FFFF, 0,  0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         0,  8, 0, 0, 0, 4'h0, 32'h0,        32'hBFFF_FFFF, 0, 4'h0, 0, 0);
        row(0, 1, 5'd8,  32'h4000_0000, 8, 24, 0, 0, 0, 4'h0, 32'h4000_0000, 32'h0,        0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         8, 24, 1, 0, 0, 4'h0, 32'h4000_0000, 32'h0,        3, 4'h0, 0, 0);
        // window 3: its r24 aliases window 0's r8; its r8 is fresh
        row(0, 0, 5'd0,  32'h0,        24,  8, 0, 0, 0, 4'h0, 32'h4000_0000, 32'h0,        3, 4'h0, 0, 0);
        // write r16 in window 3 while restoring
        row(0, 1, 5'd16, 32'h0000_1234, 16, 16, 0, 1, 0, 4'h0, 32'h0000_1234, 32'h0000_1234, 0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,        16,  8, 0, 0, 0, 4'h0, 32'h0,        32'h4000_0000, 0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  8, 0, 1, 0, 4'h0, 32'h0000_0001, 32'h4000_0000, 0, 4'h0, 0, 1);
        row(0, 0, 5'd0,  32'h0,         5,  0, 0, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 1, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        3, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 1, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        2, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 1, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        1, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 1, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        1, 4'h0, 1, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 0, 0, 0, 4'h0, 32'h0000_0001, 32'h0,        1, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 1, 1, 0, 4'h0, 32'h0000_0001, 32'h0,        1, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 0, 0, 1, 4'h9, 32'h0000_0001, 32'h0,        1, 4'h9, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  0, 0, 0, 0, 4'h6, 32'h0000_0001, 32'h0,        1, 4'h9, 0, 0);
        // reset mid-sequence overrides write, save and icc load
        row(1, 1, 5'd5,  32'h0000_00FF, 1,  2, 1, 0, 1, 4'h6, 32'h0,        32'h0,        0, 4'h0, 0, 0);
        row(0, 0, 5'd0,  32'h0,         5,  8, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 4'h0, 0, 0);
        // depth was discarded: a restore must now underflow
        row(0, 0, 5'd0,  32'h0,         5,  8, 0, 1, 0, 4'h0, 32'h0,        32'h0,        0, 4'h0, 0, 1);
        row(0, 0, 5'd0,  32'h0,        24, 16, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra_a = vecs[i].ra_a; ra_b = vecs[i].ra_b; save = vecs[i].sv; restore = vecs[i].rs;
            icc_we = vecs[i].icc_we; flags_in = vecs[i].flags;
            sb.push_back('{idx: i, cwp: vecs[i].e_cwp, icc: vecs[i].e_icc,
                           ovf: vecs[i].e_ovf, unf: vecs[i].e_unf});
            #3;
            check($sformatf("row%0d rd_a", i), rd_a, vecs[i].e_a);
            check($sformatf("row%0d rd_b", i), rd_b, vecs[i].e_b);
            @(posedge clk);
            #1;
            p = sb.pop_front();
            check($sformatf("row%0d cwp", p.idx), 32'(cwp), 32'(p.cwp));
            check($sformatf("row%0d icc", p.idx), 32'(icc), 32'(p.icc));
            check($sformatf("row%0d cin", p.idx), 32'(cin_out), 32'(p.icc[0]));
            check($sformatf("row%0d ovf", p.idx), 32'(win_overflow), 32'(p.ovf));
            check($sformatf("row%0d unf", p.idx), 32'(win_underflow), 32'(p.unf));
        end

        @(negedge clk);
        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/windowed_regfile.md
# windowed_regfile

SPARC-style windowed integer register file with an integrated integer condition-code (ICC) register, placed directly upstream of `mini_alu` in the execute path. Two read ports drive the ALU `a`/`b` operands, and one write port takes the ALU result `y` back. The ICC register latches the ALU `flags` and returns the stored carry as the ALU `cin`. Register windows rotate on `save`/`restore`, and overflow/underflow is reported instead of trapping.

## Interface
Parameters:
- `NWINDOWS`, 4: number of register windows; power of two, at least 2.
- `WIDTH`, 32: data width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: rising-edge clock.
  - `rst`, in, 1: synchronous, active-high reset.
- Read ports:
  - `ra_a`, in, 5: read address for port A.
  - `ra_b`, in, 5: read address for port B.
  - `rd_a`, out, WIDTH: port A data; drives ALU `a`.
  - `rd_b`, out, WIDTH: port B data; drives ALU `b`.
- Write port:
  - `we`, in, 1: write enable.
  - `wa`, in, 5: write address.
  - `wd`, in, WIDTH: write data; ALU `y`.
- Window control:
  - `save`, in, 1: rotate to a new window (CWP−1).
  - `restore`, in, 1: rotate back (CWP+1).
  - `cwp`, out, log2(NWINDOWS): current window pointer.
  - `win_overflow`, out, 1: one-cycle pulse when a save is refused.
  - `win_underflow`, out, 1: one-cycle pulse when a restore is refused.
- Condition codes:
  - `icc_we`, in, 1: latch `flags_in`.
  - `flags_in`, in, 4: ALU flags, ordered {N,Z,V,C}.
  - `icc`, out, 4: stored {N,Z,V,C}.
  - `cin_out`, out, 1: equals `icc[0]`; drives ALU `cin`.

## Operation
- **Address map:**
  - r0–r7 are globals at physical 0–7.
  - r8–r31 are windowed. Physical index = 8 + ((cwp·16 + (r−8)) mod (16·NWINDOWS)).
  - Total physical storage is 8 + 16·NWINDOWS words.
  - The ins (r24–r31) of window w alias the outs (r8–r15) of window w+1 mod NWINDOWS.
- **r0:** always reads 0. Writes to r0 are discarded.
- **Read bypass:** if `we` is set, `wa`==`ra_x`, and `wa`≠0, then `rd_x` = `wd` in the same cycle.
- **Window depth counter (0..NWINDOWS−1):** counts outstanding saves.
  - `save` with depth < NWINDOWS−1: cwp ← cwp−1 (mod NWINDOWS), depth+1.
  - `save` with depth = NWINDOWS−1: cwp and depth unchanged; `win_overflow`=1 for the next cycle.
  - `restore` with depth > 0: cwp ← cwp+1 (mod), depth−1.
  - `restore` with depth = 0: unchanged; `win_underflow`=1 for the next cycle.
  - `save` and `restore` asserted together: no-op, no pulse.
- **Write during save/restore:** the write address resolves through the pre-update cwp.
- **ICC:** `icc_we` latches `flags_in`; otherwise `icc` holds.

## Timing
- Reads and bypass are combinational, with zero latency.
- Register writes, cwp, depth, icc and the pulse outputs update on the rising edge of `clk`.
- A write is visible through the array (without bypass) from the cycle after the write edge.
- Pulses are registered: asserted for exactly the one cycle after the refused request.
- Reset, at an edge with `rst`=1:
  - All physical registers = 0; `cwp`=0; depth=0; `icc`=0; `cin_out`=0; `win_overflow`=`win_underflow`=0.
  - `rst` overrides `we`, `save`, `restore` and `icc_we` asserted in the same cycle.
  - Reset in the middle of a window sequence discards all window state.

## Structure
- Package `regfile_pkg`:
  - `NWINDOWS_DEFAULT`.
  - Flag bit positions `FLAG_N`=3, `FLAG_Z`=2, `FLAG_V`=1, `FLAG_C`=0.
  - Globals count (8) and window size (16).
- Sub-module `window_index_map` (combinational; inputs r, cwp; output physical index). Instantiated three times: both read ports and the write port.

## Test plan
1. **Reset:** reset, then read r0–r31 → all 0; `cwp`=0; `icc`=0000.
2. **Write/read and bypass:**
   - Write r5=0x0000_0001 and r8=0xBFFF_FFFF, then read them → values returned.
   - Same-cycle read of r8 during the write returns the new value via bypass.
   - Write r0=0xFFFF_FFFF → r0 reads 0.
3. **Aliasing on save/restore:**
   - cwp=0: write r8=0x4000_0000, then `save` → cwp=NWINDOWS−1; r24 reads 0x4000_0000.
   - Write r16=0x1234; `restore` → cwp=0; r16 reads the pre-save value (0).
4. **Overflow/underflow:**
   - NWINDOWS−1 saves succeed; the next save → `win_overflow` for 1 cycle, cwp unchanged.
   - From reset, `restore` → `win_underflow`, cwp stays 0.
   - `save` and `restore` together → no change.
5. **ICC:**
   - `icc_we` with `flags_in`=1001 → `icc`=1001, `cin_out`=1 on the next cycle.
   - `flags_in` changes with `icc_we`=0 → `icc` holds.
   - Assert `rst` with `icc_we` high → `icc`=0000.
